// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_e : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   LEN_BYTES      : bytes in the big-endian word-count header
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// loader_word_packer
// Packs an MSB-first byte stream into 32-bit words.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_clear        : restart packing at byte position 0
//   i_byte_valid   : i_byte is accepted this cycle
//   i_byte         : stream byte
//   o_byte_idx     : position of the next byte within the word (0..3)
//   o_word_valid   : one-cycle pulse, o_word holds a complete word
//   o_word         : packed word (first byte in bits [31:24])
module loader_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_idx,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic        r_word_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_byte_valid) begin
                // Shifting left keeps the first byte of the word in the top lane.
                r_shift      <= {r_shift[23:0], i_byte};
                r_idx        <= r_idx + 2'd1;
                r_word_valid <= (r_idx == LastIdx);
            end
        end
    end

    assign o_byte_idx   = r_idx;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Fills instruction memory from a byte stream: a 16-bit big-endian word count N,
// then N MSB-first 32-bit words written from byte address 0. Holds the CPU in
// reset until a load completes.
// Optional feature macro: LOADER_CHECKSUM_EN -- one trailing byte that must equal
// the XOR of all data bytes; mismatch ends in the error state.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_i            : begin a new load (honoured in idle/done/error only)
//   byte_valid_i/byte_i/byte_ready_o : byte stream handshake
//   mem_we_o/mem_addr_o/mem_data_o   : instruction-memory write port
//   cpu_hold_o         : keep CPU in reset
//   done_o, err_o      : load status
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AfterData = StCsum;
`else
    localparam loader_state_e AfterData = StDone;
`endif
    localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

    loader_state_e     r_state;
    loader_state_e     w_state_next;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_err;
    logic              r_hold;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_ready;
    logic        w_xfer;
    logic        w_start_load;
    logic [15:0] w_len_next;
    logic        w_pack_accept;
    logic        w_last_byte;
    logic [1:0]  w_byte_idx;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic        w_done_d;
    logic        w_err_d;
    logic        w_hold_d;

    assign w_xfer        = byte_valid_i && w_ready;
    assign w_start_load  = start_i && ((r_state == StIdle) || (r_state == StDone) ||
                                       (r_state == StErr));
    assign w_len_next    = {r_len_hi, byte_i};
    assign w_pack_accept = w_xfer && (r_state == StData);
    assign w_last_byte   = w_pack_accept && (w_byte_idx == LastIdx);

    loader_word_packer u_packer (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_clear      (w_start_load),
        .i_byte_valid (w_pack_accept),
        .i_byte       (byte_i),
        .o_byte_idx   (w_byte_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone, StErr: begin
                if (start_i) w_state_next = StLenHi;
            end
            StLenHi: begin
                if (w_xfer) w_state_next = StLenLo;
            end
            StLenLo: begin
                if (w_xfer) begin
                    if (w_len_next == 16'd0) begin
                        w_state_next = AfterData;
                    end else if (32'(w_len_next) > DEPTH_WORDS) begin
                        w_state_next = StErr;
                    end else begin
                        w_state_next = StData;
                    end
                end
            end
            StData: begin
                // Word count is bumped on the 4th byte, so equality here marks the
                // strobe cycle of the final word.
                if (w_word_valid && (r_word_cnt == r_len)) w_state_next = AfterData;
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (w_xfer) w_state_next = (byte_i == r_csum) ? StDone : StErr;
            end
`endif
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic: handshake from current state, status flags from next state
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            StLenHi, StLenLo: w_ready = 1'b1;
            // Stop accepting once all N words have been received.
            StData:           w_ready = (r_word_cnt < r_len);
`ifdef LOADER_CHECKSUM_EN
            StCsum:           w_ready = 1'b1;
`endif
            default:          w_ready = 1'b0;
        endcase
        w_done_d = (w_state_next == StDone);
        w_err_d  = (w_state_next == StErr);
        w_hold_d = (w_state_next != StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_hold <= 1'b1;
        end else begin
            r_done <= w_done_d;
            r_err  <= w_err_d;
            r_hold <= w_hold_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len_hi   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else if (w_start_load) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            if ((r_state == StLenHi) && w_xfer) r_len_hi <= byte_i;
            if ((r_state == StLenLo) && w_xfer) r_len <= w_len_next;
            if (w_last_byte) r_word_cnt <= r_word_cnt + 16'd1;
            // Advance after the strobe cycle so the write sees the current address.
            if (w_word_valid) r_addr <= r_addr + ADDR_W'(BYTES_PER_WORD);
`ifdef LOADER_CHECKSUM_EN
            if (w_pack_accept) r_csum <= r_csum ^ byte_i;
`endif
        end
    end

    assign byte_ready_o = w_ready;
    assign mem_we_o     = w_word_valid;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = w_word;
    assign cpu_hold_o   = r_hold;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. Expected writes and status are
// computed from the stream itself (word count, MSB-first packing, XOR checksum
// when LOADER_CHECKSUM_EN is defined).
module tb_instr_mem_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_i = 8'h00;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          cpu_hold_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stim[$];
    logic [63:0] wr_q[$];

    always #5 clk = ~clk;

    instr_mem_loader #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we_o === 1'b1) wr_q.push_back({32'(mem_addr_o), mem_data_o});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Offer one byte; returns at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int unsigned waited;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        acc          = 1'b0;
        waited       = 0;
        while (!acc && waited < 50) begin
            acc = byte_ready_o;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        byte_valid_i = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $error("FAIL send_byte_timeout: byte_ready_o observed 0 expected 1");
        end
    endtask

    function automatic logic [7:0] data_xor();
        logic [7:0] x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x ^= stim[i];
        return x;
    endfunction

    task automatic build_stream(input int unsigned n);
        stim.delete();
        stim.push_back(n[15:8]);
        stim.push_back(n[7:0]);
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(data_xor());
`endif
    endtask

    // Run one load from stim and compare against the stream-derived expectation.
    task automatic load_check(input string tag, input bit gaps);
        int unsigned n;
        int unsigned nsend;
        int unsigned exp_writes;
        int unsigned cnt;
        bit          exp_err;
        logic [7:0]  x;
        logic [31:0] w;
        n       = {16'd0, stim[0], stim[1]};
        exp_err = (n > DEPTH);
        x       = 8'h00;
        if (!exp_err) begin
            for (int i = 0; i < 4 * n; i++) x ^= stim[2 + i];
        end
        nsend      = exp_err ? 2 : 2 + 4 * n;
        exp_writes = exp_err ? 0 : n;
`ifdef LOADER_CHECKSUM_EN
        if (!exp_err) begin
            nsend++;
            exp_err = (stim[2 + 4 * n] != x);
        end
`endif
        wr_q.delete();
        do_start();
        for (int i = 0; i < nsend; i++) begin
            send_byte(stim[i], gaps);
            if (n > 0 && n <= DEPTH && i == 2 + 4 * n - 1) begin
                check({tag, "_last_we"}, 64'(mem_we_o), 64'd1);
                check({tag, "_last_done_early"}, 64'(done_o), 64'd0);
`ifndef LOADER_CHECKSUM_EN
                @(negedge clk);
                check({tag, "_done_after_strobe"}, 64'(done_o), 64'd1);
                check({tag, "_we_single"}, 64'(mem_we_o), 64'd0);
`endif
            end
`ifndef LOADER_CHECKSUM_EN
            if (n == 0 && i == 1) check({tag, "_zero_done"}, 64'(done_o), 64'd1);
`endif
        end
        cnt = 0;
        while (done_o !== 1'b1 && err_o !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_done"}, 64'(done_o), 64'(!exp_err));
        check({tag, "_err"}, 64'(err_o), 64'(exp_err));
        check({tag, "_hold"}, 64'(cpu_hold_o), 64'(exp_err));
        check({tag, "_ready_idle"}, 64'(byte_ready_o), 64'd0);
        check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_writes));
        for (int k = 0; k < exp_writes && k < wr_q.size(); k++) begin
            w = {stim[2 + 4 * k], stim[3 + 4 * k], stim[4 + 4 * k], stim[5 + 4 * k]};
            check({tag, "_write"}, wr_q[k], {32'(4 * k), w});
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(byte_ready_o), 64'd0);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_data", 64'(mem_data_o), 64'd0);
        check("rst_hold", 64'(cpu_hold_o), 64'd1);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("idle_hold", 64'(cpu_hold_o), 64'd1);

        // Basic two-word load
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(data_xor());
`endif
        load_check("basic", 1'b0);
        check("basic_w0", wr_q.size() > 0 ? wr_q[0] : 64'hX, 64'h00000000_12345678);
        check("basic_w1", wr_q.size() > 1 ? wr_q[1] : 64'hX, 64'h00000004_9ABCDEF0);

        // Zero length
        build_stream(0);
        load_check("zero", 1'b0);

        // Oversize, then recovery
        stim = '{8'h01, 8'h01};
        load_check("oversize", 1'b0);
        build_stream(3);
        load_check("recover", 1'b1);

        // Full-depth load with and without gaps
        build_stream(DEPTH);
        load_check("full_gaps", 1'b1);
        check("full_gaps_last_addr", wr_q.size() == DEPTH ? 64'(wr_q[DEPTH-1][63:32]) : 64'hX,
              64'h3FC);
        load_check("full_b2b", 1'b0);
        check("full_b2b_last_addr", wr_q.size() == DEPTH ? 64'(wr_q[DEPTH-1][63:32]) : 64'hX,
              64'h3FC);

        // Reset after the 6th byte
        build_stream(2);
        do_start();
        for (int i = 0; i < 6; i++) send_byte(stim[i], 1'b0);
        #1 rst_i = 1'b1;
        #1;
        check("midrst_ready", 64'(byte_ready_o), 64'd0);
        check("midrst_we", 64'(mem_we_o), 64'd0);
        check("midrst_addr", 64'(mem_addr_o), 64'd0);
        check("midrst_data", 64'(mem_data_o), 64'd0);
        check("midrst_hold", 64'(cpu_hold_o), 64'd1);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_err", 64'(err_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        load_check("after_rst", 1'b0);

        // Random short loads
        for (int r = 0; r < 4; r++) begin
            build_stream($urandom_range(1, 8));
            load_check("random", r[0]);
        end

`ifdef LOADER_CHECKSUM_EN
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        load_check("csum_ok", 1'b0);
        check("csum_ok_done", 64'(done_o), 64'd1);
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        load_check("csum_bad", 1'b0);
        check("csum_bad_err", 64'(err_o), 64'd1);
        check("csum_bad_writes", 64'(wr_q.size()), 64'd1);
        check("csum_bad_hold", 64'(cpu_hold_o), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
